// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB-75 row shifter: FSM encoding, line-buffer
// field layout and default geometry.
package hub75_pkg;

  localparam int DEFAULT_COLUMNS     = 64;
  localparam int DEFAULT_COLOR_DEPTH = 8;

  // Each colour field in a line-buffer word is one byte; LSB offsets below.
  localparam int FIELD_W = 8;
  localparam int R1_LSB  = 40;
  localparam int G1_LSB  = 32;
  localparam int B1_LSB  = 24;
  localparam int R2_LSB  = 16;
  localparam int G2_LSB  = 8;
  localparam int B2_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    LATCH   = 3'd2,
    DISPLAY = 3'd3,
    BLANK   = 3'd4
  } state_t;

endpackage

// File: rtl/hub75_oe_timer.sv
// Loadable down-counter that sets the length of one DISPLAY (output-enable)
// period; last is high on the final enabled cycle.
module hub75_oe_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/hub75_row_shifter.sv
// Scans one HUB-75 row: shifts every bit plane out of the line buffer, latches
// it and shows it for a binary-weighted time (BCM), then reports done.
module hub75_row_shifter
  import hub75_pkg::*;
#(
  parameter int COLUMNS     = DEFAULT_COLUMNS,
  parameter int COLOR_DEPTH = DEFAULT_COLOR_DEPTH,
  parameter int OE_BASE     = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [4:0]                 y,
  input  logic                       bank,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(COLUMNS):0]   read_address,
  input  logic [47:0]                read_data,
  output logic                       drive_r1,
  output logic                       drive_g1,
  output logic                       drive_b1,
  output logic                       drive_r2,
  output logic                       drive_g2,
  output logic                       drive_b2,
  output logic                       drive_clk,
  output logic                       drive_lat,
  output logic                       drive_oe_n,
  output logic [4:0]                 drive_addr
);

  localparam int XW = $clog2(COLUMNS);
  localparam int CW = $clog2(2 * COLUMNS + 1);
  localparam int PW = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam int TW = 8 + COLOR_DEPTH;

  state_t          state;
  logic [CW-1:0]   phase_cnt;
  logic [XW-1:0]   x;
  logic [XW-1:0]   addr_x;
  logic [PW-1:0]   p;
  logic [4:0]      row;
  logic            bank_q;
  logic            in_shift;
  logic            prime;
  logic            high_phase;
  logic            shift_last;
  logic            last_plane;
  logic            oe_last;
  logic [TW-1:0]   oe_len;
  logic [FIELD_W-1:0] f_r1, f_g1, f_b1, f_r2, f_g2, f_b2;

  // phase_cnt 0 is the read-latency prime; odd counts are the low (data
  // setup) phase of a column and even non-zero counts the high phase.
  always_comb begin
    in_shift   = (state == SHIFT);
    prime      = (phase_cnt == '0);
    high_phase = in_shift && !prime && !phase_cnt[0];
    shift_last = (phase_cnt == CW'(2 * COLUMNS));
    last_plane = (p == PW'(COLOR_DEPTH - 1));
    oe_len     = TW'(OE_BASE) << p;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      x          <= '0;
      p          <= '0;
      row        <= '0;
      bank_q     <= 1'b0;
      drive_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row       <= y;
            bank_q    <= bank;
            p         <= '0;
            x         <= '0;
            phase_cnt <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (high_phase) begin
            x <= x + XW'(1);
          end
          if (shift_last) begin
            phase_cnt  <= '0;
            drive_addr <= row;
            state      <= LATCH;
          end else begin
            phase_cnt <= phase_cnt + CW'(1);
          end
        end
        LATCH:   state <= DISPLAY;
        DISPLAY: if (oe_last) state <= BLANK;
        BLANK: begin
          if (last_plane) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            p     <= p + PW'(1);
            state <= SHIFT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  hub75_oe_timer #(
    .WIDTH (TW)
  ) oe_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (state == LATCH),
    .enable (state == DISPLAY),
    .value  (oe_len),
    .last   (oe_last)
  );

  // During the high phase the address already points at the next column so
  // its data arrives in time for that column's low phase.
  always_comb begin
    addr_x       = high_phase ? x + XW'(1) : x;
    read_address = {bank_q, addr_x};
  end

  always_comb begin
    f_r1 = read_data[R1_LSB +: FIELD_W];
    f_g1 = read_data[G1_LSB +: FIELD_W];
    f_b1 = read_data[B1_LSB +: FIELD_W];
    f_r2 = read_data[R2_LSB +: FIELD_W];
    f_g2 = read_data[G2_LSB +: FIELD_W];
    f_b2 = read_data[B2_LSB +: FIELD_W];
  end

  always_comb begin
    drive_r1   = in_shift && !prime && f_r1[p];
    drive_g1   = in_shift && !prime && f_g1[p];
    drive_b1   = in_shift && !prime && f_b1[p];
    drive_r2   = in_shift && !prime && f_r2[p];
    drive_g2   = in_shift && !prime && f_g2[p];
    drive_b2   = in_shift && !prime && f_b2[p];
    drive_clk  = high_phase;
    drive_lat  = (state == LATCH);
    drive_oe_n = (state != DISPLAY);
  end

endmodule
